// File: rtl/return_stack_ctrl.sv
// Return-address stack controller: push on StW, pop on StR, simultaneous push/pop replaces the top,
// popped PC returned two edges after acceptance, sticky overflow/underflow flags for debug.
module return_stack_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8,
    parameter int SP_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    input  logic              clear_err,
    output logic              ready,
    output logic [ADDR_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              empty,
    output logic              full,
    output logic [SP_W-1:0]   sp,
    output logic              overflow,
    output logic              underflow
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        IDLE     = 1'b0,
        POP_WAIT = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] hold;

    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  top_idx;
    logic              accept;
    logic              do_push;
    logic              do_pop;
    logic              do_replace;
    logic              push_on_empty;
    logic              ovf_set;
    logic              unf_set;

    assign ready = (state == IDLE);
    assign empty = (sp == '0);
    assign full  = (sp == SP_W'(DEPTH));

    // DEPTH is a power of two, so the low index bits of sp wrap DEPTH to 0 and top_idx lands on DEPTH-1.
    always_comb begin
        wr_idx        = sp[IDX_W-1:0];
        top_idx       = wr_idx - IDX_W'(1);
        accept        = (state == IDLE);
        do_push       = accept & push & ~pop & ~full;
        ovf_set       = accept & push & ~pop & full;
        do_pop        = accept & pop & ~push & ~empty;
        do_replace    = accept & push & pop & ~empty;
        push_on_empty = accept & push & pop & empty;
        unf_set       = accept & pop & empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sp        <= '0;
            hold      <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            pop_valid <= 1'b0;
            overflow  <= ovf_set | (overflow & ~clear_err);
            underflow <= unf_set | (underflow & ~clear_err);

            case (state)
                IDLE: begin
                    if (do_push || push_on_empty) begin
                        mem[wr_idx] <= push_data;
                        sp          <= sp + SP_W'(1);
                    end
                    if (do_pop) begin
                        hold  <= mem[top_idx];
                        sp    <= sp - SP_W'(1);
                        state <= POP_WAIT;
                    end
                    // Replace: the old top is returned and overwritten in the same edge.
                    if (do_replace) begin
                        hold         <= mem[top_idx];
                        mem[top_idx] <= push_data;
                        state        <= POP_WAIT;
                    end
                end
                POP_WAIT: begin
                    pop_data  <= hold;
                    pop_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sp_in_range: assert property (@(posedge clk) disable iff (!rst_n) sp <= SP_W'(DEPTH));
    valid_is_pulse: assert property (@(posedge clk) disable iff (!rst_n) pop_valid |=> !pop_valid);

endmodule
